serial_comparator: RTL and testbench
====================================

Name: serial_comparator

Overview:
- Bit-serial, LSB-first magnitude comparator of two WIDTH-bit operands. One bit of each operand arrives per accepted cycle.
- Produces registered equal/greater/smaller flags and a one-cycle done pulse.
- Sequential counterpart to the team's parallel MSB-first combinational comparator. Used where operands arrive over serial links or shift registers.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new comparison; honoured only in IDLE or DONE
- bit_valid  input  1  a_bit/b_bit carry a valid bit this cycle; honoured only in RUN
- a_bit  input  1  serial operand A, LSB first
- b_bit  input  1  serial operand B, LSB first
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is updated
- e  output  1  A == B (registered)
- g  output  1  A > B (registered)
- s  output  1  A < B (registered)

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, internal relation=EQ. busy=0, done=0, e=0, g=0, s=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN; counter=0, relation=EQ. bit_valid is ignored in IDLE, including the start cycle itself.
  - RUN: busy=1. Each cycle with bit_valid=1 consumes one bit pair and increments the counter.
    - a_bit != b_bit: relation becomes GT if a_bit=1, else LT.
    - a_bit == b_bit: relation unchanged.
    - Because bits arrive LSB first, the last differing bit decides the result.
    - bit_valid=0: no change, counter holds; gaps of any length are legal.
    - When the consumed bit is index WIDTH-1, go to DONE.
  - DONE (exactly one cycle): done=1. e/g/s load from the final relation, which includes the last bit. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back comparisons).
- Latency: flags and done become valid on the clock edge after the last bit is accepted (1 cycle). Minimum total time is WIDTH+2 cycles from start to done.
- Outputs e/g/s are exactly one-hot after the first completed comparison. They hold their value until the next DONE; a new start does not clear them.
- start during RUN is ignored; the comparison continues.
- rst mid-operation aborts immediately to reset values; partial bits are discarded.
- WIDTH=1: a single accepted bit goes straight to DONE.
- Counter width is max(1, $clog2(WIDTH)). No wrap occurs because the counter is cleared on entry to RUN.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. On bit index WIDTH-1 (the sign bit), when a_bit != b_bit, relation becomes LT if a_bit=1, else GT. This inverts the unsigned rule for the sign bit only. Equal sign bits leave the relation unchanged.
- Undefined: all bits, including WIDTH-1, use the unsigned rule.

Decomposition:
- Package serial_cmp_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the relation enum (EQ, GT, LT);
  - a localparam function for counter width.
- Single module. The per-bit relation update is a small combinational function in the package, not a sub-module.

Test Plan:
- Unsigned greater: WIDTH=4, A=1010 (10), B=0110 (6), bits LSB first with no gaps -> done at cycle start+6; g=1, e=0, s=0.
- Equal with gaps: A=B=0101, bit_valid toggling 1,0,1,0... -> done only after 4 valid bits; e=1. busy stays high throughout the gaps.
- Back-to-back: after A=0011 vs B=1100 (s=1), start asserted in the DONE cycle with a second pair A=1111, B=1110 -> s held until the second DONE, then g=1. No IDLE cycle between the two comparisons.
- Protocol robustness: start re-asserted mid-RUN, and bit_valid asserted in IDLE -> neither changes the counter or result. Reset asserted after 2 bits -> all outputs 0 immediately; a fresh compare then completes correctly.
- Signed feature: A=1000, B=0001. With SERIAL_CMP_SIGNED_EN -> s=1 (-8 < 1). Without it -> g=1 (8 > 1).
- WIDTH=1 instance: start, then one bit a=1, b=0 -> done one cycle later, g=1.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared types and helpers for serial_comparator.
// SERIAL_CMP_SIGNED_EN selects two's-complement handling of the sign bit.
package serial_cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {EQ, GT, LT} rel_t;
`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  function automatic int cnt_width(input int width);
    return width > 1 ? $clog2(width) : 1;
  endfunction
  // LSB first: a differing bit overrides all lower bits; a signed sign bit inverts the sense
  function automatic rel_t rel_next(input rel_t rel, input logic a, input logic b, input logic msb);
    return a == b ? rel : ((a ^ (msb & SIGNED_EN)) ? GT : LT);
  endfunction
endpackage

// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial LSB-first magnitude comparator with registered e/g/s flags.
// Define SERIAL_CMP_SIGNED_EN to compare two's-complement operands.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic e,
  output logic g,
  output logic s
);
  localparam int CW = cnt_width(WIDTH);
  state_t state;
  rel_t rel;
  rel_t rel_upd;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  assign rel_upd = rel_next(rel, a_bit, b_bit, last);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rel <= EQ;
      busy <= 1'b0;
      done <= 1'b0;
      e <= 1'b0;
      g <= 1'b0;
      s <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            cnt <= '0;
            rel <= EQ;
            busy <= 1'b1;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (bit_valid) begin
            rel <= rel_upd;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= DONE;
              busy <= 1'b0;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          e <= rel == EQ;
          g <= rel == GT;
          s <= rel == LT;
          state <= start ? RUN : IDLE;
          busy <= start;
          cnt <= '0;
          rel <= EQ;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed scoreboard bench for WIDTH=4 and WIDTH=1 instances.
module tb_serial_comparator;
  logic clk = 1'b0;
  logic rst;
  logic start, bit_valid, a_bit, b_bit, busy, done, e, g, s;
  logic start1, bit_valid1, a_bit1, b_bit1, busy1, done1, e1, g1, s1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_comparator #(.WIDTH(4)) u (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy), .done(done), .e(e), .g(g), .s(s)
  );
  serial_comparator #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bit_valid(bit_valid1), .a_bit(a_bit1), .b_bit(b_bit1),
    .busy(busy1), .done(done1), .e(e1), .g(g1), .s(s1)
  );

  // Signed order maps onto unsigned order by flipping the sign bit
  function automatic logic [2:0] model(input int w, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x, y;
    x = a;
    y = b;
`ifdef SERIAL_CMP_SIGNED_EN
    x[w-1] = ~x[w-1];
    y[w-1] = ~y[w-1];
`endif
    return x == y ? 3'b100 : (x > y ? 3'b010 : 3'b001);
  endfunction

  function automatic logic [2:0] obs(input bit sel);
    return sel ? {e1, g1, s1} : {e, g, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic set_in(input bit sel, input logic st, input logic bv, input logic a, input logic b);
    if (sel) begin
      start1 = st; bit_valid1 = bv; a_bit1 = a; b_bit1 = b;
    end else begin
      start = st; bit_valid = bv; a_bit = a; b_bit = b;
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic bv, input logic a, input logic b);
    set_in(sel, st, bv, a, b);
    @(negedge clk);
  endtask

  // mode 0: no gaps, 1: random gaps, 2: a gap before every bit after the first
  task automatic send(input bit sel, input logic [3:0] a, input logic [3:0] b, input int mode, output int ng);
    int w;
    w = sel ? 1 : 4;
    ng = 0;
    for (int i = 0; i < w; i++) begin
      if (i > 0 && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1))) begin
        drive(sel, 1'b0, 1'b0, ~a[i], b[i]);
        ng++;
        if (mode == 2) chk("gap busy", busy, 1);
      end
      drive(sel, 1'b0, 1'b1, a[i], b[i]);
    end
  endtask

  task automatic wait_done(input bit sel, input string tag, input int c0, input int lat);
    for (int k = 0; k < 40 && !(sel ? done1 : done); k++) @(negedge clk);
    chk({tag, " done"}, sel ? done1 : done, 1);
    chk({tag, " latency"}, cyc - c0, lat);
    if (exp_q.size() == 0) chk({tag, " queue empty"}, 0, 1);
    else chk({tag, " flags"}, obs(sel), exp_q.pop_front());
  endtask

  task automatic compare(input bit sel, input logic [3:0] a, input logic [3:0] b, input int mode, input string tag);
    int c0, ng;
    c0 = cyc;
    exp_q.push_back(model(sel ? 1 : 4, a, b));
    drive(sel, 1'b1, 1'b0, 1'b0, 1'b0);
    send(sel, a, b, mode, ng);
    set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(sel, tag, c0, (sel ? 1 : 4) + 2 + ng);
  endtask

  initial begin
    int c0, c1, ng;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset u", {busy, done, e, g, s}, 5'b0);
    chk("reset u1", {busy1, done1, e1, g1, s1}, 5'b0);
    rst = 1'b0;
    @(negedge clk);

    compare(0, 4'b1010, 4'b0110, 0, "ugt");
    @(negedge clk);
    chk("ugt pulse end", done, 0);
    chk("ugt hold", obs(0), 3'b010);

    compare(0, 4'b0101, 4'b0101, 2, "eq_gaps");

    c0 = cyc;
    exp_q.push_back(model(4, 4'b0011, 4'b1100));
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(0, 4'b0011, 4'b1100, 0, ng);
    exp_q.push_back(model(4, 4'b1111, 4'b1110));
    c1 = cyc;
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(0, "b2b first", c0, 6);
    chk("b2b no idle", busy, 1);
    send(0, 4'b1111, 4'b1110, 0, ng);
    chk("b2b hold", obs(0), 3'b001);
    set_in(0, 0, 0, 0, 0);
    wait_done(0, "b2b second", c1, 6);

    set_in(0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle bv busy", busy, 0);
    chk("idle bv done", done, 0);
    c0 = cyc;
    exp_q.push_back(model(4, 4'b0000, 4'b0001));
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start in run busy", busy, 1);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_in(0, 0, 0, 0, 0);
    wait_done(0, "protocol", c0, 6);

    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    set_in(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk("mid reset", {busy, done, e, g, s}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare(0, 4'b0101, 4'b0100, 0, "after reset");

    compare(0, 4'b1000, 4'b0001, 0, "signed");
    repeat (6) compare(0, 4'($urandom), 4'($urandom), 1, "random");

    compare(1, 4'b0001, 4'b0000, 0, "w1 a1b0");
    compare(1, 4'b0000, 4'b0001, 0, "w1 a0b1");
    compare(1, 4'b0001, 4'b0001, 0, "w1 eq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
